// File: rtl/neuron_adder.sv
// Adder stage of the spiking convolution: gathers one partial sum per PE for the
// current output row, integrates it into that row's membrane potential, and emits a spike packet.
module neuron_adder #(
    parameter int              WIDTH      = 34,
    parameter int              WIDTH_addr = 4,
    parameter int              WIDTH_data = 8,
    parameter int              POT_WIDTH  = 10,
    parameter logic [3:0]      MY_ADDR    = 4'b1000,
    parameter logic [3:0]      OUT_ADDR   = 4'b1100,
    parameter logic [3:0]      PE1_addr   = 4'b0100,
    parameter logic [3:0]      PE2_addr   = 4'b0101,
    parameter logic [3:0]      PE3_addr   = 4'b0110,
    parameter int              NUM_ROWS   = 3,
    parameter int              THRESHOLD  = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             ts_done,
    output logic             err,
    output logic [1:0]       dbg_state
);

    // Handshakes: a beat transfers on the rising edge where valid && ready are both high;
    // a producer holds valid and data stable until that edge, and valid never depends on ready.

    localparam logic [1:0] COLLECT = 2'b00;
    localparam logic [1:0] FIRE    = 2'b01;
    localparam logic [1:0] SEND    = 2'b10;

    localparam int ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam logic [ROW_W-1:0]     LAST_ROW = ROW_W'(NUM_ROWS - 1);
    localparam logic [POT_WIDTH-1:0] THR      = POT_WIDTH'(THRESHOLD);
    localparam logic [1:0]           PSUM_TYPE = 2'b10;

    logic [1:0]           state;
    logic                 ready_en;
    logic [ROW_W-1:0]     row;
    logic [2:0]           rx_mask;
    logic [POT_WIDTH-1:0] psum;
    logic [POT_WIDTH-1:0] pot [NUM_ROWS];

    logic [WIDTH_addr-1:0] pkt_src;
    logic [WIDTH_addr-1:0] pkt_dst;
    logic [1:0]            pkt_type;
    logic [WIDTH_data-1:0] pkt_val;
    logic [2:0]            src_bit;
    logic [2:0]            mask_next;
    logic                  in_xfer;
    logic                  legal;
    logic                  dup;
    logic                  accept;

    logic [POT_WIDTH:0]   v_full;
    logic [POT_WIDTH-1:0] v_sat;
    logic [POT_WIDTH-1:0] pot_new;
    logic                 spike;
    logic [1:0]           row_pad;
    logic [WIDTH-1:0]     result_pkt;

    // ready_en keeps in_ready low from reset assertion until the first edge after release
    assign in_ready  = ready_en && (state == COLLECT);
    assign dbg_state = state;

    assign pkt_src  = in_data[WIDTH-1 -: WIDTH_addr];
    assign pkt_dst  = in_data[WIDTH-1-WIDTH_addr -: WIDTH_addr];
    assign pkt_type = in_data[WIDTH-1-2*WIDTH_addr -: 2];
    assign pkt_val  = in_data[WIDTH_data-1:0];

    always_comb begin
        src_bit = 3'b000;
        if (pkt_src == PE1_addr) src_bit = 3'b001;
        else if (pkt_src == PE2_addr) src_bit = 3'b010;
        else if (pkt_src == PE3_addr) src_bit = 3'b100;
    end

    assign in_xfer   = in_valid && in_ready;
    assign legal     = (pkt_dst == MY_ADDR) && (pkt_type == PSUM_TYPE) && (src_bit != 3'b000);
    assign dup       = (src_bit & rx_mask) != 3'b000;
    assign accept    = legal && !dup;
    assign mask_next = rx_mask | src_bit;

    // Saturate the 11-bit sum before the threshold compare so overflow still fires
    assign v_full  = {1'b0, pot[row]} + {1'b0, psum};
    assign v_sat   = v_full[POT_WIDTH] ? {POT_WIDTH{1'b1}} : v_full[POT_WIDTH-1:0];
    assign spike   = (v_sat >= THR);
    assign pot_new = spike ? (v_sat - THR) : v_sat;
    assign row_pad = 2'(row);

    assign result_pkt = {MY_ADDR, OUT_ADDR, 2'b11, 6'b0, pot_new, 4'b0, row_pad, 1'b0, spike};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= COLLECT;
            ready_en  <= 1'b0;
            row       <= '0;
            rx_mask   <= 3'b000;
            psum      <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            ts_done   <= 1'b0;
            err       <= 1'b0;
            for (int i = 0; i < NUM_ROWS; i++) begin
                pot[i] <= '0;
            end
        end else begin
            ready_en <= 1'b1;
            ts_done  <= 1'b0;
            err      <= 1'b0;
            case (state)
                COLLECT: begin
                    if (in_xfer) begin
                        if (accept) begin
                            rx_mask <= mask_next;
                            psum    <= psum + POT_WIDTH'(pkt_val);
                            if (mask_next == 3'b111) begin
                                state <= FIRE;
                            end
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                FIRE: begin
                    pot[row]  <= pot_new;
                    out_data  <= result_pkt;
                    out_valid <= 1'b1;
                    rx_mask   <= 3'b000;
                    psum      <= '0;
                    state     <= SEND;
                end
                SEND: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= COLLECT;
                        if (row == LAST_ROW) begin
                            row     <= '0;
                            ts_done <= 1'b1;
                        end else begin
                            row <= row + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= COLLECT;
                end
            endcase
        end
    end

    a_out_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid && !out_ready) |=> (out_valid && $stable(out_data)));

    a_no_input_when_busy: assert property (@(posedge clk) disable iff (!rst_n)
        (state != COLLECT) |-> !in_ready);

endmodule
